// File: rtl/lcd_pkg.sv
// Shared command codes, decoder states and RGB565 helper for the LCD SPI receiver.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [1:0] {IDLE, CASET, RASET, RAMWR} dec_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic rgb565_t rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/lcd_spi_rx_if.sv
// LCD SPI link pins plus the decoded receive outputs of lcd_spi_rx.
interface lcd_spi_rx_if #(
    parameter int unsigned COORD_W = 9
) ();
    logic               lcd_spi_sclk;
    logic               lcd_spi_mosi;
    logic               lcd_spi_cs;
    logic               lcd_dc;
    logic               lcd_reset;
    logic [7:0]         rx_byte;
    logic               rx_dc;
    logic               rx_valid;
    logic               cmd_valid;
    logic [7:0]         cmd_code;
    logic               pix_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [15:0]        pix_data;
    logic               frame_done;
    logic               abort;

    modport master (
        output lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc, lcd_reset,
        input  rx_byte, rx_dc, rx_valid, cmd_valid, cmd_code, pix_valid, pix_x, pix_y,
        input  pix_data, frame_done, abort
    );

    modport slave (
        input  lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc, lcd_reset,
        output rx_byte, rx_dc, rx_valid, cmd_valid, cmd_code, pix_valid, pix_x, pix_y,
        output pix_data, frame_done, abort
    );
endinterface

// File: rtl/lcd_spi_byte_rx.sv
// Synchronizes the SPI pins, detects sclk rising edges and assembles MSB-first bytes.
module lcd_spi_byte_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       cs_i,
    input  logic       dc_i,
    input  logic       lcd_reset_i,
    output logic       soft_rst_o,
    output logic [7:0] byte_o,
    output logic       dc_o,
    output logic       valid_o,
    output logic       cmd_valid_o,
    output logic [7:0] cmd_code_o,
    output logic       abort_o
);
    // Sync vector order: {lcd_reset, dc, cs, mosi, sclk}; cs idles deselected, panel held in reset.
    localparam logic [4:0] SyncRst = 5'b00100;

    logic [4:0] sync1_q, sync2_q;
    logic       sclk_d_q, rise_q, mosi_q, dc_q, cs_q;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] sreg_q, sreg_d;
    logic [7:0] byte_q, byte_d, code_q, code_d;
    logic       dc_out_q, dc_out_d, valid_q, valid_d, cmd_q, cmd_d, abort_q, abort_d;

    assign soft_rst_o = ~sync2_q[4];

    // Edge detect sits one stage behind the synchronizer; all link bits are delayed equally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= SyncRst;
            sync2_q  <= SyncRst;
            sclk_d_q <= 1'b0;
            rise_q   <= 1'b0;
            mosi_q   <= 1'b0;
            dc_q     <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            sync1_q  <= {lcd_reset_i, dc_i, cs_i, mosi_i, sclk_i};
            sync2_q  <= sync1_q;
            sclk_d_q <= sync2_q[0];
            rise_q   <= sync2_q[0] & ~sclk_d_q;
            mosi_q   <= sync2_q[1];
            cs_q     <= sync2_q[2];
            dc_q     <= sync2_q[3];
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        byte_d   = byte_q;
        code_d   = code_q;
        dc_out_d = dc_out_q;
        valid_d  = 1'b0;
        cmd_d    = 1'b0;
        abort_d  = 1'b0;
        if (soft_rst_o) begin
            cnt_d  = '0;
            sreg_d = '0;
        end else if (cs_q) begin
            cnt_d   = '0;
            abort_d = (cnt_q != 3'd0);
        end else if (rise_q) begin
            sreg_d = {sreg_q[5:0], mosi_q};
            if (cnt_q == 3'd7) begin
                cnt_d    = '0;
                byte_d   = {sreg_q, mosi_q};
                dc_out_d = dc_q;
                valid_d  = 1'b1;
                cmd_d    = ~dc_q;
                if (!dc_q) code_d = {sreg_q, mosi_q};
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sreg_q   <= '0;
            byte_q   <= '0;
            code_q   <= '0;
            dc_out_q <= 1'b0;
            valid_q  <= 1'b0;
            cmd_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sreg_q   <= sreg_d;
            byte_q   <= byte_d;
            code_q   <= code_d;
            dc_out_q <= dc_out_d;
            valid_q  <= valid_d;
            cmd_q    <= cmd_d;
            abort_q  <= abort_d;
        end
    end

    assign byte_o      = byte_q;
    assign dc_o        = dc_out_q;
    assign valid_o     = valid_q;
    assign cmd_valid_o = cmd_q;
    assign cmd_code_o  = code_q;
    assign abort_o     = abort_q;
endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI panel receiver: decodes CASET/RASET/RAMWR into windowed RGB565 pixel writes.
module lcd_spi_rx
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES   = 240,
    parameter int unsigned V_RES   = 320,
    parameter int unsigned COORD_W = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    lcd_spi_rx_if.slave   bus
);
    localparam logic [COORD_W-1:0] XeRst = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] YeRst = COORD_W'(V_RES - 1);

    logic       soft_rst, rx_valid, rx_dc;
    logic [7:0] rx_byte;

    lcd_spi_byte_rx u_byte_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_i      (bus.lcd_spi_sclk),
        .mosi_i      (bus.lcd_spi_mosi),
        .cs_i        (bus.lcd_spi_cs),
        .dc_i        (bus.lcd_dc),
        .lcd_reset_i (bus.lcd_reset),
        .soft_rst_o  (soft_rst),
        .byte_o      (rx_byte),
        .dc_o        (rx_dc),
        .valid_o     (rx_valid),
        .cmd_valid_o (bus.cmd_valid),
        .cmd_code_o  (bus.cmd_code),
        .abort_o     (bus.abort)
    );

    dec_state_e         state_q, state_d;
    logic [1:0]         pcnt_q, pcnt_d;
    logic [7:0]         p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, hi_q, hi_d;
    logic               hi_vld_q, hi_vld_d, pix_valid_q, pix_valid_d, frame_q, frame_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    rgb565_t            pix_data_q, pix_data_d;

    always_comb begin
        state_d = state_q;   pcnt_d = pcnt_q;
        p0_d = p0_q;         p1_d = p1_q;         p2_d = p2_q;
        hi_d = hi_q;         hi_vld_d = hi_vld_q;
        xs_d = xs_q;         xe_d = xe_q;         ys_d = ys_q;         ye_d = ye_q;
        x_d = x_q;           y_d = y_q;
        pix_x_d = pix_x_q;   pix_y_d = pix_y_q;   pix_data_d = pix_data_q;
        pix_valid_d = 1'b0;  frame_d = 1'b0;
        if (soft_rst) begin
            state_d = IDLE;  pcnt_d = '0;  hi_vld_d = 1'b0;
            xs_d = '0;  xe_d = XeRst;  ys_d = '0;  ye_d = YeRst;
            x_d = '0;   y_d = '0;
        end else if (rx_valid && !rx_dc) begin
            pcnt_d   = '0;
            hi_vld_d = 1'b0;
            case (rx_byte)
                CMD_CASET: state_d = CASET;
                CMD_RASET: state_d = RASET;
                CMD_RAMWR: begin
                    state_d = RAMWR;
                    x_d     = xs_q;
                    y_d     = ys_q;
                end
                default:   state_d = IDLE;
            endcase
        end else if (rx_valid) begin
            case (state_q)
                CASET, RASET: begin
                    pcnt_d = pcnt_q + 2'd1;
                    unique case (pcnt_q)
                        2'd0: p0_d = rx_byte;
                        2'd1: p1_d = rx_byte;
                        2'd2: p2_d = rx_byte;
                        2'd3: begin
                            state_d = IDLE;
                            if (state_q == CASET) begin
                                xs_d = COORD_W'({p0_q, p1_q});
                                xe_d = COORD_W'({p2_q, rx_byte});
                            end else begin
                                ys_d = COORD_W'({p0_q, p1_q});
                                ye_d = COORD_W'({p2_q, rx_byte});
                            end
                        end
                    endcase
                end
                RAMWR: begin
                    if (!hi_vld_q) begin
                        hi_d     = rx_byte;
                        hi_vld_d = 1'b1;
                    end else begin
                        hi_vld_d    = 1'b0;
                        pix_valid_d = 1'b1;
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        pix_data_d  = rgb565_pack(hi_q, rx_byte);
                        frame_d     = (x_q == xe_q) && (y_q == ye_q);
                        // An inverted window pins the axis to its start and always wraps.
                        if (x_q == xe_q || xs_q > xe_q) begin
                            x_d = xs_q;
                            y_d = (y_q == ye_q || ys_q > ye_q) ? ys_q : y_q + COORD_W'(1);
                        end else begin
                            x_d = x_q + COORD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;  pcnt_q <= '0;
            p0_q <= '0;  p1_q <= '0;  p2_q <= '0;  hi_q <= '0;  hi_vld_q <= 1'b0;
            xs_q <= '0;  xe_q <= XeRst;  ys_q <= '0;  ye_q <= YeRst;
            x_q <= '0;   y_q <= '0;
            pix_valid_q <= 1'b0;  frame_q <= 1'b0;
            pix_x_q <= '0;  pix_y_q <= '0;  pix_data_q <= '0;
        end else begin
            state_q <= state_d;  pcnt_q <= pcnt_d;
            p0_q <= p0_d;  p1_q <= p1_d;  p2_q <= p2_d;  hi_q <= hi_d;  hi_vld_q <= hi_vld_d;
            xs_q <= xs_d;  xe_q <= xe_d;  ys_q <= ys_d;  ye_q <= ye_d;
            x_q <= x_d;    y_q <= y_d;
            pix_valid_q <= pix_valid_d;  frame_q <= frame_d;
            pix_x_q <= pix_x_d;  pix_y_q <= pix_y_d;  pix_data_q <= pix_data_d;
        end
    end

    assign bus.rx_byte    = rx_byte;
    assign bus.rx_dc      = rx_dc;
    assign bus.rx_valid   = rx_valid;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_data   = pix_data_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: drives SPI bytes and checks decoded bytes, commands and pixels.
module tb_lcd_spi_rx;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_spi_rx_if #(.COORD_W(9)) bus ();

    lcd_spi_rx #(.H_RES(240), .V_RES(320), .COORD_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event log captured on the falling edge.
    int          rx_cnt = 0, cmd_cnt = 0, abort_cnt = 0, pix_cnt = 0;
    logic [7:0]  last_byte = '0, last_code = '0;
    logic        last_dc = 1'b0;
    logic [8:0]  px_log[$], py_log[$];
    logic [15:0] pd_log[$];
    logic        fd_log[$];

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt++;
            last_byte = bus.rx_byte;
            last_dc   = bus.rx_dc;
        end
        if (bus.cmd_valid) begin
            cmd_cnt++;
            last_code = bus.cmd_code;
        end
        if (bus.abort) abort_cnt++;
        if (bus.pix_valid) begin
            pix_cnt++;
            px_log.push_back(bus.pix_x);
            py_log.push_back(bus.pix_y);
            pd_log.push_back(bus.pix_data);
            fd_log.push_back(bus.frame_done);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input bit chk_lat);
        bus.lcd_spi_mosi = b;
        wait_clk(4);
        bus.lcd_spi_sclk = 1'b1;
        if (chk_lat) begin
            repeat (3) @(posedge clk);
            #1;
            n_checks++;
            if (bus.rx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_early: rx_valid=%b required 0", bus.rx_valid);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.rx_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL latency_edge: rx_valid=%b required 1", bus.rx_valid);
            end
            #1;
        end else begin
            wait_clk(4);
        end
        bus.lcd_spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input bit chk_lat);
        bus.lcd_dc = dc;
        for (int i = 7; i >= 0; i--) send_bit(b[i], chk_lat && (i == 0));
        wait_clk(2);
    endtask

    task automatic send_pixel(input logic [15:0] p);
        send_byte(p[15:8], 1'b1, 1'b0);
        send_byte(p[7:0], 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.lcd_spi_sclk = 1'b0;
        bus.lcd_spi_mosi = 1'b0;
        bus.lcd_spi_cs   = 1'b1;
        bus.lcd_dc       = 1'b0;
        bus.lcd_reset    = 1'b1;
        wait_clk(3);
        n_checks++;
        if ({bus.rx_byte, bus.rx_dc, bus.rx_valid, bus.cmd_valid, bus.cmd_code, bus.pix_valid,
             bus.pix_x, bus.pix_y, bus.pix_data, bus.frame_done, bus.abort} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rx_byte=%h pix_x=%0d pix_data=%h required all 0",
                     bus.rx_byte, bus.pix_x, bus.pix_data);
        end
        rst_n = 1'b1;
        wait_clk(5);
        n_checks++;
        if ({bus.rx_valid, bus.pix_valid, bus.abort, bus.cmd_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: strobes=%b required 0000",
                     {bus.rx_valid, bus.pix_valid, bus.abort, bus.cmd_valid});
        end
    endtask

    task automatic test_reset_mid_byte;
        int r0 = rx_cnt, c0 = cmd_cnt, a0 = abort_cnt;
        logic [7:0] a5 = 8'hA5;
        bus.lcd_spi_cs = 1'b0;
        wait_clk(2);
        bus.lcd_dc = 1'b0;
        for (int i = 7; i >= 3; i--) send_bit(a5[i], 1'b0);
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        send_byte(8'h3C, 1'b0, 1'b0);
        wait_clk(6);
        bus.lcd_spi_cs = 1'b1;
        wait_clk(6);
        n_checks++;
        if (abort_cnt - a0 != 0) begin
            n_fail++; $display("FAIL mid_rst_abort: aborts=%0d required 0", abort_cnt - a0);
        end
        n_checks++;
        if (rx_cnt - r0 != 1) begin
            n_fail++; $display("FAIL mid_rst_rxcnt: rx_valid=%0d required 1", rx_cnt - r0);
        end
        n_checks++;
        if (last_byte !== 8'h3C) begin
            n_fail++; $display("FAIL mid_rst_byte: rx_byte=%h required 3c", last_byte);
        end
        n_checks++;
        if (last_dc !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_dc: rx_dc=%b required 0", last_dc);
        end
        n_checks++;
        if (cmd_cnt - c0 != 1) begin
            n_fail++; $display("FAIL mid_rst_cmdcnt: cmd_valid=%0d required 1", cmd_cnt - c0);
        end
        n_checks++;
        if (last_code !== 8'h3C) begin
            n_fail++; $display("FAIL mid_rst_code: cmd_code=%h required 3c", last_code);
        end
    endtask

    task automatic test_byte_path;
        int r0 = rx_cnt, p0 = pix_cnt, a0 = abort_cnt;
        bus.lcd_spi_cs = 1'b0;
        wait_clk(2);
        send_byte(8'h2C, 1'b0, 1'b1);
        send_byte(8'hF8, 1'b1, 1'b0);
        // Deselect between the two pixel bytes; the high byte must be kept.
        bus.lcd_spi_cs = 1'b1;
        wait_clk(4);
        bus.lcd_spi_cs = 1'b0;
        wait_clk(2);
        send_byte(8'h00, 1'b1, 1'b0);
        wait_clk(6);
        n_checks++;
        if (rx_cnt - r0 != 3) begin
            n_fail++; $display("FAIL bp_rxcnt: rx_valid=%0d required 3", rx_cnt - r0);
        end
        n_checks++;
        if (last_code !== 8'h2C) begin
            n_fail++; $display("FAIL bp_code: cmd_code=%h required 2c", last_code);
        end
        n_checks++;
        if (abort_cnt - a0 != 0) begin
            n_fail++; $display("FAIL bp_abort: aborts=%0d required 0", abort_cnt - a0);
        end
        n_checks++;
        if (pix_cnt - p0 != 1) begin
            n_fail++; $display("FAIL bp_pixcnt: pix_valid=%0d required 1", pix_cnt - p0);
        end else begin
            n_checks++;
            if (px_log[p0] !== 9'd0 || py_log[p0] !== 9'd0) begin
                n_fail++;
                $display("FAIL bp_xy: (%0d,%0d) required (0,0)", px_log[p0], py_log[p0]);
            end
            n_checks++;
            if (pd_log[p0] !== 16'hF800) begin
                n_fail++; $display("FAIL bp_data: pix_data=%h required f800", pd_log[p0]);
            end
        end
    endtask

    task automatic test_window_wrap;
        int p0 = pix_cnt;
        logic [8:0] ex[5] = '{9'd10, 9'd11, 9'd10, 9'd11, 9'd10};
        logic [8:0] ey[5] = '{9'd20, 9'd20, 9'd21, 9'd21, 9'd20};
        send_byte(8'h2A, 1'b0, 1'b0);
        send_byte(8'd0, 1'b1, 1'b0);  send_byte(8'd10, 1'b1, 1'b0);
        send_byte(8'd0, 1'b1, 1'b0);  send_byte(8'd11, 1'b1, 1'b0);
        send_byte(8'h2B, 1'b0, 1'b0);
        send_byte(8'd0, 1'b1, 1'b0);  send_byte(8'd20, 1'b1, 1'b0);
        send_byte(8'd0, 1'b1, 1'b0);  send_byte(8'd21, 1'b1, 1'b0);
        send_byte(8'h2C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_pixel(16'hA000 + 16'(i));
        wait_clk(6);
        n_checks++;
        if (pix_cnt - p0 != 5) begin
            n_fail++; $display("FAIL win_pixcnt: pix_valid=%0d required 5", pix_cnt - p0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (px_log[p0+i] !== ex[i] || py_log[p0+i] !== ey[i]) begin
                    n_fail++;
                    $display("FAIL win_xy[%0d]: (%0d,%0d) required (%0d,%0d)", i,
                             px_log[p0+i], py_log[p0+i], ex[i], ey[i]);
                end
                n_checks++;
                if (pd_log[p0+i] !== 16'hA000 + 16'(i)) begin
                    n_fail++;
                    $display("FAIL win_data[%0d]: pix_data=%h required %h", i, pd_log[p0+i],
                             16'hA000 + 16'(i));
                end
                n_checks++;
                if (fd_log[p0+i] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL win_frame[%0d]: frame_done=%b required %b", i, fd_log[p0+i],
                             (i == 3));
                end
            end
        end
    endtask

    task automatic test_abort;
        int r0 = rx_cnt, a0 = abort_cnt;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        bus.lcd_spi_cs = 1'b1;
        wait_clk(6);
        n_checks++;
        if (abort_cnt - a0 != 1) begin
            n_fail++; $display("FAIL abort_pulse: aborts=%0d required 1", abort_cnt - a0);
        end
        n_checks++;
        if (rx_cnt - r0 != 0) begin
            n_fail++; $display("FAIL abort_discard: rx_valid=%0d required 0", rx_cnt - r0);
        end
        bus.lcd_spi_cs = 1'b0;
        wait_clk(2);
        send_byte(8'h2A, 1'b0, 1'b0);
        wait_clk(6);
        n_checks++;
        if (rx_cnt - r0 != 1 || last_byte !== 8'h2A) begin
            n_fail++;
            $display("FAIL abort_next_byte: count=%0d byte=%h required 1 and 2a", rx_cnt - r0,
                     last_byte);
        end
        n_checks++;
        if (last_code !== 8'h2A) begin
            n_fail++; $display("FAIL abort_next_code: cmd_code=%h required 2a", last_code);
        end
        n_checks++;
        if (abort_cnt - a0 != 1) begin
            n_fail++; $display("FAIL abort_single: aborts=%0d required 1", abort_cnt - a0);
        end
    endtask

    task automatic test_lcd_reset;
        int r0, p0, a0;
        send_byte(8'h2C, 1'b0, 1'b0);
        send_byte(8'hAB, 1'b1, 1'b0);
        r0 = rx_cnt; p0 = pix_cnt; a0 = abort_cnt;
        bus.lcd_reset = 1'b0;
        wait_clk(8);
        bus.lcd_reset = 1'b1;
        wait_clk(6);
        n_checks++;
        if (rx_cnt - r0 != 0 || pix_cnt - p0 != 0 || abort_cnt - a0 != 0) begin
            n_fail++;
            $display("FAIL lrst_no_pulse: rx=%0d pix=%0d abort=%0d required 0 0 0",
                     rx_cnt - r0, pix_cnt - p0, abort_cnt - a0);
        end
        send_byte(8'h2C, 1'b0, 1'b0);
        send_pixel(16'h1234);
        wait_clk(6);
        n_checks++;
        if (pix_cnt - p0 != 1) begin
            n_fail++; $display("FAIL lrst_pixcnt: pix_valid=%0d required 1", pix_cnt - p0);
        end else begin
            n_checks++;
            if (px_log[p0] !== 9'd0 || py_log[p0] !== 9'd0) begin
                n_fail++;
                $display("FAIL lrst_xy: (%0d,%0d) required (0,0)", px_log[p0], py_log[p0]);
            end
            n_checks++;
            if (pd_log[p0] !== 16'h1234) begin
                n_fail++; $display("FAIL lrst_data: pix_data=%h required 1234", pd_log[p0]);
            end
        end
    endtask

    task automatic test_cmd_interrupt;
        int p0 = pix_cnt;
        send_byte(8'h2A, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        send_byte(8'h2C, 1'b0, 1'b0);
        send_pixel(16'h5678);
        send_pixel(16'h9ABC);
        wait_clk(6);
        n_checks++;
        if (pix_cnt - p0 != 2) begin
            n_fail++; $display("FAIL int_pixcnt: pix_valid=%0d required 2", pix_cnt - p0);
        end else begin
            n_checks++;
            if (px_log[p0] !== 9'd0 || py_log[p0] !== 9'd0 || pd_log[p0] !== 16'h5678) begin
                n_fail++;
                $display("FAIL int_pix0: (%0d,%0d) %h required (0,0) 5678", px_log[p0],
                         py_log[p0], pd_log[p0]);
            end
            n_checks++;
            if (px_log[p0+1] !== 9'd1 || py_log[p0+1] !== 9'd0) begin
                n_fail++;
                $display("FAIL int_pix1: (%0d,%0d) required (1,0)", px_log[p0+1], py_log[p0+1]);
            end
        end
    endtask

    task automatic test_degenerate;
        int p0 = pix_cnt;
        logic [8:0] ey[3] = '{9'd0, 9'd1, 9'd0};
        send_byte(8'h2A, 1'b0, 1'b0);
        send_byte(8'd0, 1'b1, 1'b0);  send_byte(8'd5, 1'b1, 1'b0);
        send_byte(8'd0, 1'b1, 1'b0);  send_byte(8'd3, 1'b1, 1'b0);
        send_byte(8'h2B, 1'b0, 1'b0);
        send_byte(8'd0, 1'b1, 1'b0);  send_byte(8'd0, 1'b1, 1'b0);
        send_byte(8'd0, 1'b1, 1'b0);  send_byte(8'd1, 1'b1, 1'b0);
        send_byte(8'h2C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_pixel(16'h0F00 + 16'(i));
        wait_clk(6);
        n_checks++;
        if (pix_cnt - p0 != 3) begin
            n_fail++; $display("FAIL deg_pixcnt: pix_valid=%0d required 3", pix_cnt - p0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (px_log[p0+i] !== 9'd5 || py_log[p0+i] !== ey[i] || fd_log[p0+i] !== 1'b0)
                begin
                    n_fail++;
                    $display("FAIL deg_pix[%0d]: (%0d,%0d) fd=%b required (5,%0d) fd=0", i,
                             px_log[p0+i], py_log[p0+i], fd_log[p0+i], ey[i]);
                end
            end
        end
        bus.lcd_spi_cs = 1'b1;
        wait_clk(4);
    endtask

    initial begin
        test_reset();
        test_reset_mid_byte();
        test_byte_path();
        test_window_wrap();
        test_abort();
        test_lcd_reset();
        test_cmd_interrupt();
        test_degenerate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_spi_rx.md
Name: lcd_spi_rx

Overview:
- Receiving end of the 4-wire LCD SPI link driven by the display controller: lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc and lcd_reset.
- Oversamples the link on the system clock, assembles bytes MSB-first, and tracks CASET/RASET/RAMWR to emit decoded pixel writes with (x, y) coordinates.
- Used as a synthesizable panel model in simulation, and as an on-chip loopback checker next to top.

Parameters:
- H_RES, 240, panel width in pixels; reset value of the column end is H_RES-1.
- V_RES, 320, panel height in pixels; reset value of the row end is V_RES-1.
- COORD_W, 9, width of the coordinate registers and outputs.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- lcd_spi_sclk  in  1  SPI clock from the controller; idle low; data sampled on its rising edge.
- lcd_spi_mosi  in  1  SPI data, MSB first.
- lcd_spi_cs  in  1  chip select, active low.
- lcd_dc  in  1  0 = command byte, 1 = data byte.
- lcd_reset  in  1  panel reset, active low.
- rx_byte  out  8  last assembled byte.
- rx_dc  out  1  lcd_dc value sampled with bit 0 of rx_byte.
- rx_valid  out  1  one-cycle pulse per assembled byte.
- cmd_valid  out  1  one-cycle pulse per command byte (rx_dc = 0).
- cmd_code  out  8  code of the last command byte.
- pix_valid  out  1  one-cycle pulse per completed RGB565 pixel.
- pix_x  out  COORD_W  column of the pixel.
- pix_y  out  COORD_W  row of the pixel.
- pix_data  out  16  RGB565 pixel value, high byte received first.
- frame_done  out  1  one-cycle pulse, coincident with pix_valid, for the pixel at (xe, ye).
- abort  out  1  one-cycle pulse when cs deasserts mid-byte.

Behaviour:
- All five link inputs pass through 2-FF synchronizers. Timing requirement on the link: sclk high and low phases each last at least 3 clk periods.
- Reset (rst_n low): all outputs 0; bit counter 0; decoder state IDLE; window xs=0, xe=H_RES-1, ys=0, ye=V_RES-1; x=y=0.
- Shift register: on a synchronized sclk rising edge with synchronized cs low, shift in mosi and increment the bit counter (0..7).
  - On the 8th bit, latch rx_byte and rx_dc (dc sampled on the same edge) and pulse rx_valid.
  - Latency: rx_valid rises exactly 3 clk cycles after the first clk edge that samples the 8th sclk high at the pin.
- cs high: bit counter cleared. If the counter was nonzero when cs rose, pulse abort and discard the partial byte. Decoder state is kept; a pixel's high byte survives a cs toggle between bytes.
- Synchronized lcd_reset low acts like rst_n on the shift register, decoder and window, except that it does not itself pulse any output.
- Decoder FSM, advanced only on rx_valid:
  - IDLE: a data byte is ignored. A command byte pulses cmd_valid and loads cmd_code (same cycle as rx_valid) and selects the next state: 0x2A -> CASET, 0x2B -> RASET, 0x2C -> RAMWR (x<=xs, y<=ys, hi-flag cleared), any other code -> IDLE.
  - Any command byte in any state behaves as in IDLE and aborts the current sequence.
  - CASET: 4 data bytes XS_H, XS_L, XE_H, XE_L. Values are truncated to COORD_W and committed to xs/xe only after the 4th byte. Then -> IDLE; further data bytes are ignored.
  - RASET: same structure for ys/ye.
  - RAMWR: first data byte is stored as the high byte. The second data byte produces pix_valid one cycle after its rx_valid, with pix_x = x, pix_y = y and pix_data = {hi, lo}. Then advance the position:
    - x == xe: x <= xs, then advance y (y == ye: y <= ys; otherwise y+1).
    - otherwise: x+1.
    - frame_done pulses with the pixel at (xe, ye).
  - RAMWR persists until the next command byte.
- Degenerate window: if xs > xe, x stays at xs and every pixel advances y. If ys > ye, y stays at ys.
- Window registers persist across cs cycles and across RAMWR sessions.

Decomposition:
- Package lcd_pkg holds:
  - command constants CMD_CASET = 8'h2A, CMD_RASET = 8'h2B, CMD_RAMWR = 8'h2C;
  - the decoder state enum {IDLE, CASET, RASET, RAMWR};
  - an RGB565 field helper.
- Natural sub-module: lcd_spi_byte_rx (synchronizers, edge detect, shift register, abort) feeding the decoder FSM in lcd_spi_rx.

Test Plan:
- Reset mid-byte: send 5 bits of 0xA5, assert rst_n low, then send the full byte 0x3C -> no abort; rx_byte = 0x3C, rx_dc = 0, cmd_valid once.
- Byte path: send cmd 0x2C then data 0xF8, 0x00 -> rx_valid x3; cmd_code = 0x2C; pix_valid once with pix_x = 0, pix_y = 0, pix_data = 16'hF800.
- Window and wrap: CASET 0,10,0,11; RASET 0,20,0,21; RAMWR with 5 pixels -> coordinates (10,20), (11,20), (10,21), (11,21) with frame_done on the 4th, then (10,20).
- Abort: cs rises after 3 bits -> abort pulse; the next full byte 0x2A decodes correctly.
- Command interrupts: CASET with only 2 params, then RAMWR and 1 pixel -> pixel at (0,0); xs/xe unchanged.
- lcd_reset: during RAMWR after a high byte, pulse lcd_reset low, then send 0x2C, 0x12, 0x34 -> pix_data = 16'h1234 at (0,0) with the default window.
